// File: rtl/alu_arbiter_pkg.sv
// Shared ALU opcode encodings, the defined-opcode predicate and arbiter types.
// Used by the ALU, the round-robin arbiter and the alu_arbiter top.
package alu_arbiter_pkg;

  localparam int unsigned ALU_DATA_W = 32;
  localparam int unsigned ALU_OP_W   = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9,
    ALU_LUI  = 4'd10,
    ALU_XXX  = 4'd15
  } alu_op_e;

  // Which port was granted most recently.
  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  // Single source of truth for which encodings the ALU defines.
  function automatic logic alu_op_valid(input logic [ALU_OP_W-1:0] op);
    case (op)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT,
      ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI: return 1'b1;
      default:                                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// Shared 32-bit combinational ALU; undefined opcodes produce zero.
module alu
  import alu_arbiter_pkg::*;
(
  input  logic [ALU_DATA_W-1:0] a_i,
  input  logic [ALU_DATA_W-1:0] b_i,
  input  logic [ALU_OP_W-1:0]   op_i,
  output logic [ALU_DATA_W-1:0] out_o
);

  always_comb begin
    out_o = '0;
    case (op_i)
      ALU_ADD:  out_o = a_i + b_i;
      ALU_SUB:  out_o = a_i - b_i;
      ALU_AND:  out_o = a_i & b_i;
      ALU_OR:   out_o = a_i | b_i;
      ALU_XOR:  out_o = a_i ^ b_i;
      ALU_SLT:  out_o = {{(ALU_DATA_W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_SLTU: out_o = {{(ALU_DATA_W-1){1'b0}}, (a_i < b_i)};
      ALU_SLL:  out_o = a_i << b_i[4:0];
      ALU_SRL:  out_o = a_i >> b_i[4:0];
      ALU_SRA:  out_o = $unsigned($signed(a_i) >>> b_i[4:0]);
      ALU_LUI:  out_o = b_i;
      default:  out_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant; a tie goes to the port not granted last.
module rr_arb2
  import alu_arbiter_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] elig_i,
  output logic [1:0] grant_o
);

  port_e last_q, last_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) last_q <= PORT1;
    else         last_q <= last_d;
  end

  always_comb begin
    grant_o = '0;
    last_d  = last_q;
    case (elig_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = (last_q == PORT1) ? 2'b01 : 2'b10;
      default: grant_o = '0;
    endcase
    if (grant_o[1])      last_d = PORT1;
    else if (grant_o[0]) last_d = PORT0;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two valid/ready requesters with round-robin grant and
// a registered per-port response. Define ALU_ARB_ERR_EN to add rsp0_err/rsp1_err.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_data,
`ifdef ALU_ARB_ERR_EN
  output logic              rsp0_err,
  output logic              rsp1_err,
`endif
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_data
);

  if (DATA_W != 32) begin : g_bad_data_w
    $error("alu_arbiter: DATA_W must be 32 to match the ALU");
  end

  logic [1:0]             elig, grant, rsp_ready;
  logic [DATA_W-1:0]      alu_a, alu_b, alu_out, result;
  logic [OP_W-1:0]        alu_op;
  logic                   op_bad;
  logic [1:0]             rsp_valid_q, rsp_valid_d;
  logic [1:0][DATA_W-1:0] rsp_data_q, rsp_data_d;

  assign rsp_ready = {rsp1_ready, rsp0_ready};

  // A port with a stalled response may not issue again until it drains.
  assign elig[0] = req0_valid && (!rsp_valid_q[0] || rsp0_ready);
  assign elig[1] = req1_valid && (!rsp_valid_q[1] || rsp1_ready);

  rr_arb2 u_rr_arb2 (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .elig_i  (elig),
    .grant_o (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = ALU_XXX;
    if (grant[0]) begin
      alu_a  = req0_a;
      alu_b  = req0_b;
      alu_op = req0_op;
    end else if (grant[1]) begin
      alu_a  = req1_a;
      alu_b  = req1_b;
      alu_op = req1_op;
    end
  end

  alu u_alu (
    .a_i   (alu_a),
    .b_i   (alu_b),
    .op_i  (alu_op),
    .out_o (alu_out)
  );

  assign op_bad = !alu_op_valid(alu_op);
  assign result = op_bad ? '0 : alu_out;

  // Grant implies valid, so a grant is an accept; accept wins over consume.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    for (int unsigned i = 0; i < 2; i++) begin
      if (grant[i]) begin
        rsp_valid_d[i] = 1'b1;
        rsp_data_d[i]  = result;
      end else if (rsp_ready[i]) begin
        rsp_valid_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp0_valid = rsp_valid_q[0];
  assign rsp1_valid = rsp_valid_q[1];
  assign rsp0_data  = rsp_data_q[0];
  assign rsp1_data  = rsp_data_q[1];

`ifdef ALU_ARB_ERR_EN
  logic [1:0] rsp_err_q, rsp_err_d;

  always_comb begin
    rsp_err_d = rsp_err_q;
    for (int unsigned i = 0; i < 2; i++) begin
      if (grant[i]) rsp_err_d[i] = op_bad;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rsp_err_q <= '0;
    else          rsp_err_q <= rsp_err_d;
  end

  assign rsp0_err = rsp_err_q[0];
  assign rsp1_err = rsp_err_q[1];
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a reference grant/ALU model pushes expected
// responses on predicted accepts; they are popped when the DUT's response is consumed.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  rsp_ready = '1;
  logic [31:0] req_a [2];
  logic [31:0] req_b [2];
  logic [3:0]  req_op [2];
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_data, rsp1_data;
`ifdef ALU_ARB_ERR_EN
  logic        rsp0_err, rsp1_err;
`endif

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(32), .OP_W(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req0_valid (req_valid[0]),
    .req0_ready (req0_ready),
    .req0_a     (req_a[0]),
    .req0_b     (req_b[0]),
    .req0_op    (req_op[0]),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp_ready[0]),
    .rsp0_data  (rsp0_data),
`ifdef ALU_ARB_ERR_EN
    .rsp0_err   (rsp0_err),
    .rsp1_err   (rsp1_err),
`endif
    .req1_valid (req_valid[1]),
    .req1_ready (req1_ready),
    .req1_a     (req_a[1]),
    .req1_b     (req_b[1]),
    .req1_op    (req_op[1]),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp_ready[1]),
    .rsp1_data  (rsp1_data)
  );

  typedef struct {
    int          port;
    logic [31:0] data;
    logic        err;
  } sb_t;

  sb_t  sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit [1:0] m_valid = '0;
  bit   m_last = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic ref_defined(input logic [3:0] op);
    return (op <= 4'd10);
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:    return (a < b) ? 32'd1 : 32'd0;
      4'd7:    return a << b[4:0];
      4'd8:    return a >> b[4:0];
      4'd9:    return $unsigned($signed(a) >>> b[4:0]);
      4'd10:   return b;
      default: return 32'd0;
    endcase
  endfunction

  // One clock: called at a negedge with inputs already driven.
  task automatic cycle();
    bit [1:0]    elig, grant;
    logic [31:0] data_o;
    logic        err_o;
    int          idx;
    #1;
    for (int p = 0; p < 2; p++)
      elig[p] = req_valid[p] && (!m_valid[p] || rsp_ready[p]);
    if (elig == 2'b11) grant = m_last ? 2'b01 : 2'b10;
    else               grant = elig;
    check("req_ready", {30'd0, req1_ready, req0_ready}, {30'd0, grant});
    check("rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, {30'd0, m_valid});
    for (int p = 0; p < 2; p++) begin
      if (m_valid[p]) begin
        idx = -1;
        foreach (sb[k]) if (idx < 0 && sb[k].port == p) idx = k;
        check("sb_has_entry", {31'd0, idx >= 0}, 32'd1);
        if (idx >= 0) begin
          data_o = (p == 0) ? rsp0_data : rsp1_data;
          check(p == 0 ? "rsp0_data" : "rsp1_data", data_o, sb[idx].data);
`ifdef ALU_ARB_ERR_EN
          err_o = (p == 0) ? rsp0_err : rsp1_err;
          check(p == 0 ? "rsp0_err" : "rsp1_err", {31'd0, err_o}, {31'd0, sb[idx].err});
`else
          err_o = 1'b0;
`endif
          if (rsp_ready[p]) sb.delete(idx);
        end
      end
    end
    for (int p = 0; p < 2; p++)
      if (grant[p]) sb.push_back('{p, ref_alu(req_op[p], req_a[p], req_b[p]), !ref_defined(req_op[p])});
    @(posedge clk);
    for (int p = 0; p < 2; p++)
      if (grant[p])          m_valid[p] = 1'b1;
      else if (rsp_ready[p]) m_valid[p] = 1'b0;
    if (grant[1])      m_last = 1'b1;
    else if (grant[0]) m_last = 1'b0;
    @(negedge clk);
  endtask

  task automatic drive(input logic v0, input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                       input logic r0, input logic v1, input logic [3:0] op1, input logic [31:0] a1,
                       input logic [31:0] b1, input logic r1);
    req_valid = {v1, v0};
    rsp_ready = {r1, r0};
    req_op[0] = op0; req_a[0] = a0; req_b[0] = b0;
    req_op[1] = op1; req_a[1] = a1; req_b[1] = b1;
    cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, ALU_XXX, 0, 0, 1, 0, ALU_XXX, 0, 0, 1);
  endtask

  // Asserts reset a little after a negedge and checks outputs clear with no clock edge.
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    check("rst_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    check("rst_data0", rsp0_data, 32'd0);
    check("rst_data1", rsp1_data, 32'd0);
`ifdef ALU_ARB_ERR_EN
    check("rst_err", {30'd0, rsp1_err, rsp0_err}, 32'd0);
`endif
    m_valid = '0;
    m_last  = 1'b1;
    sb.delete();
    req_valid = '0;
    rsp_ready = '1;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    req_a  = '{32'd0, 32'd0};
    req_b  = '{32'd0, 32'd0};
    req_op = '{4'd15, 4'd15};
    @(negedge clk);
    do_reset();

    // Single request: ADD 5+3 on port 0.
    drive(1, ALU_ADD, 32'd5, 32'd3, 1, 0, ALU_XXX, 0, 0, 1);
    idle(2);

    // Tie straight after reset goes to port 0, then grants alternate.
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 4; i++)
      drive(1, ALU_SUB, 32'd3, 32'd5, 1, 1, ALU_XOR, 32'hFF, 32'h0F, 1);
    idle(2);

    // Backpressure on port 0 while port 1 streams.
    drive(1, ALU_ADD, 32'd5, 32'd3, 0, 0, ALU_XXX, 0, 0, 1);
    for (int i = 0; i < 3; i++)
      drive(1, ALU_ADD, 32'd1, 32'd1, 0, 1, ALU_OR, 32'(i), 32'h100, 1);
    drive(1, ALU_ADD, 32'd1, 32'd1, 1, 1, ALU_AND, 32'hF0F0, 32'hFF00, 1);
    idle(2);

    // Back-to-back on port 0.
    drive(1, ALU_SLTU, 32'd1, 32'd2, 1, 0, ALU_XXX, 0, 0, 1);
    drive(1, ALU_SLT, 32'hFFFFFFFF, 32'd0, 1, 0, ALU_XXX, 0, 0, 1);
    idle(2);

    // Undefined opcodes on port 1.
    drive(0, ALU_XXX, 0, 0, 1, 1, ALU_XXX, 32'd7, 32'd9, 1);
    drive(0, ALU_XXX, 0, 0, 1, 1, 4'd12, 32'd7, 32'd9, 1);
    idle(2);

    // Random mix, including undefined encodings and stalls.
    for (int i = 0; i < 60; i++)
      drive($urandom_range(0, 1), 4'($urandom_range(0, 15)), $urandom, $urandom, $urandom_range(0, 3) != 0,
            $urandom_range(0, 1), 4'($urandom_range(0, 15)), $urandom, $urandom, $urandom_range(0, 3) != 0);
    idle(3);

    // Reset mid-stream with a held port 0 result; the held result is dropped.
    drive(1, ALU_ADD, 32'd5, 32'd3, 0, 0, ALU_XXX, 0, 0, 1);
    drive(0, ALU_XXX, 0, 0, 0, 0, ALU_XXX, 0, 0, 1);
    check("held_valid", {31'd0, rsp0_valid}, 32'd1);
    do_reset();
    drive(1, ALU_OR, 32'h1, 32'h2, 1, 1, ALU_SLL, 32'h1, 32'd4, 1);
    drive(1, ALU_OR, 32'h1, 32'h2, 1, 1, ALU_SLL, 32'h1, 32'd4, 1);
    idle(3);

    check("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
